// File: rtl/fpdiv_pkg.sv
// Shared constants for the iterative fixed-point divider.
// Word/fraction widths, FSM encoding and saturation values.
package fpdiv_pkg;

  localparam int N  = 32;
  localparam int D  = 16;
  localparam int W  = N + D;
  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [N-1:0] SAT_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SAT_NEG = {1'b1, {(N-1){1'b0}}};

  // Magnitude of a two's complement word; -2^(N-1) maps to 2^(N-1).
  function automatic logic [N-1:0] abs_val(input logic [N-1:0] x);
    return x[N-1] ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/fpdiv_datapath.sv
// Restoring-division datapath: magnitudes, shift/subtract
// step and final sign/saturation into the result register.
module fpdiv_datapath
  import fpdiv_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic         fix,
  input  logic         zero,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] result
);

  logic         sign_q;
  logic         a_neg_q;
  logic [N-1:0] abs_a;
  logic [N-1:0] abs_b;
  logic [N-1:0] dvs_q;
  logic [W-1:0] dvd_q;
  logic [W-1:0] dvd_sh;
  logic [W-1:0] dvd_nxt;
  logic [N:0]   rem_q;
  logic [N:0]   rem_sh;
  logic [N:0]   rem_sub;
  logic [N:0]   rem_step;
  logic [N:0]   rem_nxt;
  logic [W-1:0] quo_q;
  logic [W-1:0] quo_step;
  logic [W-1:0] quo_nxt;
  logic [N-1:0] res_nxt;
  logic         ge;
  logic         en;
  logic         big_pos;
  logic         big_neg;

  assign abs_a = abs_val(a);
  assign abs_b = abs_val(b);
  assign en    = load | step;

  vc_EnResetReg #(.p_nbits(1)) sign_reg (
    .clk(clk), .reset(reset), .q(sign_q),
    .d(a[N-1] ^ b[N-1]), .en(load)
  );

  vc_EnResetReg #(.p_nbits(1)) aneg_reg (
    .clk(clk), .reset(reset), .q(a_neg_q),
    .d(a[N-1]), .en(load)
  );

  vc_EnResetReg #(.p_nbits(N)) dvs_reg (
    .clk(clk), .reset(reset), .q(dvs_q),
    .d(abs_b), .en(load)
  );

  assign dvd_sh = {dvd_q[W-2:0], 1'b0};

  vc_Mux2 #(.p_nbits(W)) dvd_mux (
    .in0(dvd_sh), .in1({abs_a, {D{1'b0}}}),
    .sel(load), .out(dvd_nxt)
  );

  vc_EnResetReg #(.p_nbits(W)) dvd_reg (
    .clk(clk), .reset(reset), .q(dvd_q),
    .d(dvd_nxt), .en(en)
  );

  // Top remainder bit acts as the carry of the shifted value.
  assign rem_sh  = {rem_q[N-1:0], dvd_q[W-1]};
  assign rem_sub = rem_sh - {1'b0, dvs_q};
  assign ge      = rem_q[N] | (rem_sh >= {1'b0, dvs_q});

  vc_Mux2 #(.p_nbits(N+1)) rsel_mux (
    .in0(rem_sh), .in1(rem_sub),
    .sel(ge), .out(rem_step)
  );

  vc_Mux2 #(.p_nbits(N+1)) rem_mux (
    .in0(rem_step), .in1({(N+1){1'b0}}),
    .sel(load), .out(rem_nxt)
  );

  vc_EnResetReg #(.p_nbits(N+1)) rem_reg (
    .clk(clk), .reset(reset), .q(rem_q),
    .d(rem_nxt), .en(en)
  );

  assign quo_step = {quo_q[W-2:0], ge};

  vc_Mux2 #(.p_nbits(W)) quo_mux (
    .in0(quo_step), .in1({W{1'b0}}),
    .sel(load), .out(quo_nxt)
  );

  vc_EnResetReg #(.p_nbits(W)) quo_reg (
    .clk(clk), .reset(reset), .q(quo_q),
    .d(quo_nxt), .en(en)
  );

  assign big_pos = |quo_q[W-1:N-1];
  assign big_neg = (|quo_q[W-1:N])
                 | (quo_q[N-1] & (|quo_q[N-2:0]));

  always_comb begin
    res_nxt = quo_q[N-1:0];
    if (zero)
      res_nxt = a_neg_q ? SAT_NEG : SAT_POS;
    else if (sign_q)
      res_nxt = big_neg ? SAT_NEG : (~quo_q[N-1:0] + 1'b1);
    else
      res_nxt = big_pos ? SAT_POS : quo_q[N-1:0];
  end

  vc_EnResetReg #(.p_nbits(N)) res_reg (
    .clk(clk), .reset(reset), .q(result),
    .d(res_nxt), .en(fix)
  );

endmodule

// File: rtl/vc_EnResetReg.sv
// Library register with synchronous reset and load enable.
module vc_EnResetReg #(
  parameter int                 p_nbits       = 1,
  parameter logic [p_nbits-1:0] p_reset_value = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [p_nbits-1:0] q,
  input  logic [p_nbits-1:0] d,
  input  logic               en
);

  always_ff @(posedge clk) begin
    if (reset)
      q <= p_reset_value;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/vc_Mux2.sv
// Library two-input multiplexer.
module vc_Mux2 #(
  parameter int p_nbits = 1
) (
  input  logic [p_nbits-1:0] in0,
  input  logic [p_nbits-1:0] in1,
  input  logic               sel,
  output logic [p_nbits-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/fpdiv.sv
// Iterative fixed-point divider c = (a << D) / b with
// val/rdy streams; FSM and step counter live here.
module fpdiv
  import fpdiv_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           istream_val,
  output logic           istream_rdy,
  input  logic [2*N-1:0] istream_msg,
  output logic           ostream_val,
  input  logic           ostream_rdy,
  output logic [N-1:0]   ostream_msg
);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic          zero_q;
  logic          load;
  logic          step;
  logic          fix;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          b_zero;

  assign a      = istream_msg[2*N-1:N];
  assign b      = istream_msg[N-1:0];
  assign b_zero = (b == '0);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    fix       = 1'b0;
    case (state)
      IDLE: begin
        if (istream_val) begin
          load      = 1'b1;
          state_nxt = b_zero ? FIX : CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt == CW'(W - 1))
          state_nxt = FIX;
      end
      FIX: begin
        fix       = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        if (ostream_rdy)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      zero_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        cnt    <= '0;
        zero_q <= b_zero;
      end else if (step) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign istream_rdy = (state == IDLE);
  assign ostream_val = (state == DONE);

  fpdiv_datapath dp (
    .clk(clk),
    .reset(reset),
    .load(load),
    .step(step),
    .fix(fix),
    .zero(zero_q),
    .a(a),
    .b(b),
    .result(ostream_msg)
  );

endmodule

// File: tb/tb_fpdiv.sv
// Bench for fpdiv: directed cases plus random pairs checked
// against a signed-arithmetic reference with clamping.
module tb_fpdiv;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        istream_val = 1'b0;
  logic        istream_rdy;
  logic [63:0] istream_msg = '0;
  logic        ostream_val;
  logic        ostream_rdy = 1'b0;
  logic [31:0] ostream_msg;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fpdiv dut (
    .clk(clk),
    .reset(reset),
    .istream_val(istream_val),
    .istream_rdy(istream_rdy),
    .istream_msg(istream_msg),
    .ostream_val(ostream_val),
    .ostream_rdy(ostream_rdy),
    .ostream_msg(ostream_msg)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Signed division truncates toward zero, then clamp to range.
  function automatic logic [31:0] model(input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0)
      return (sa >= 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    q = (sa * 65536) / sb;
    if (q > 64'sd2147483647)
      return 32'h7FFF_FFFF;
    if (q < -64'sd2147483648)
      return 32'h8000_0000;
    return q[31:0];
  endfunction

  task automatic do_job(input string tag,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int stall);
    logic [31:0] exp;
    int lat;
    int want;
    exp  = model(a, b);
    want = (b == 32'h0) ? 2 : 50;
    check({tag, "_idle"}, 32'(istream_rdy), 32'd1);
    istream_val = 1'b1;
    istream_msg = {a, b};
    @(posedge clk);
    #1;
    lat = 1;
    while (!ostream_val && lat < 200) begin
      istream_val = 1'($urandom);
      istream_msg = {$urandom, $urandom};
      ostream_rdy = (lat < want - 2) ? 1'($urandom) : 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    istream_val = 1'b0;
    check({tag, "_lat"}, 32'(lat), 32'(want));
    check({tag, "_msg"}, ostream_msg, exp);
    check({tag, "_busy"}, 32'(istream_rdy), 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold"}, ostream_msg, exp);
      check({tag, "_hval"}, 32'(ostream_val), 32'd1);
      check({tag, "_hrdy"}, 32'(istream_rdy), 32'd0);
    end
    ostream_rdy = 1'b1;
    @(posedge clk);
    #1;
    ostream_rdy = 1'b0;
    check({tag, "_rel"}, 32'(istream_rdy), 32'd1);
    check({tag, "_relv"}, 32'(ostream_val), 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        seen;

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_irdy", 32'(istream_rdy), 32'd1);
    check("rst_oval", 32'(ostream_val), 32'd0);
    check("rst_omsg", ostream_msg, 32'h0);

    do_job("six_two", 32'h0006_0000, 32'h0002_0000, 10);
    check("six_two_abs", model(32'h0006_0000, 32'h0002_0000),
          32'h0003_0000);
    do_job("one_three", 32'h0001_0000, 32'h0003_0000, 0);
    do_job("neg_7p5", 32'hFFF8_8000, 32'h0002_0000, 1);
    do_job("one_m3", 32'h0001_0000, 32'hFFFD_0000, 0);
    do_job("dz_pos", 32'h0001_0000, 32'h0000_0000, 2);
    do_job("dz_neg", 32'hFFFF_0000, 32'h0000_0000, 0);
    do_job("dz_zero", 32'h0000_0000, 32'h0000_0000, 0);
    do_job("ovf_pos", 32'h7FFF_0000, 32'h0000_0001, 0);
    do_job("min_one", 32'h8000_0000, 32'h0001_0000, 0);
    do_job("min_m1", 32'h8000_0000, 32'hFFFF_0000, 0);
    do_job("ovf_neg", 32'h8000_0000, 32'h0000_0003, 0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'($urandom_range(1, 255));
        1: rb = -32'($urandom_range(1, 70000));
        2: ra = 32'($signed(ra) >>> $urandom_range(8, 30));
        3: rb = (i % 3 == 0) ? 32'h0 : rb;
        default: ;
      endcase
      do_job("rand", ra, rb, int'($urandom_range(0, 3)));
    end

    istream_val = 1'b1;
    istream_msg = {32'h0006_0000, 32'h0002_0000};
    @(posedge clk);
    #1;
    istream_val = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_rst_irdy", 32'(istream_rdy), 32'd1);
    check("mid_rst_oval", 32'(ostream_val), 32'd0);
    check("mid_rst_omsg", ostream_msg, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (ostream_val)
        seen = 1'b1;
    end
    check("mid_rst_noval", 32'(seen), 32'd0);
    do_job("after_rst", 32'h0006_0000, 32'h0002_0000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
